tile_draw_arbiter: RTL
======================

TILE_DRAW_ARBITER -- requirements
Module: tile_draw_arbiter

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 16, tile edge in pixels; power of two, 2..64.
REQ-002 SHALL have parameter GAP, default 4, pixel spacing between adjacent tiles.
REQ-003 SHALL have parameter X_BASE, default 40, x of tile 0 origin.
REQ-004 SHALL have parameter Y_BASE, default 20, y of tile 0 origin.
REQ-005 SHALL have port clock  in  1  sole clock, rising edge.
REQ-006 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  in  3  paint request per requester: 0=boot painter, 1=sequence playback, 2=player echo.
REQ-008 SHALL have port tile_in  in  6  packed 2-bit tile number per requester; requester i uses bits [2i+1:2i].
REQ-009 SHALL have port colour_in  in  9  packed 3-bit colour per requester; requester i uses bits [3i+2:3i].
REQ-010 SHALL have port gnt  out  3  one-hot grant, high from LOAD through PAINT.
REQ-011 SHALL have port done  out  3  one-cycle completion pulse to the granted requester.
REQ-012 SHALL have ports x  out  8, y  out  7, colour  out  3, writeEn  out  1, which drive the VGA adapter.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> LOAD -> PAINT -> DONE -> IDLE; all outputs registered.
REQ-015 IDLE: SHALL stay in IDLE while req==0; on any req bit high, SHALL pick a winner, latch its tile and colour, set gnt, and go to LOAD.
REQ-016 Default arbitration SHALL be fixed priority 0 > 1 > 2.
REQ-017 LOAD, one cycle: SHALL compute origin x = X_BASE + tile[0]*(TILE_SIZE+GAP) and y = Y_BASE + tile[1]*(TILE_SIZE+GAP), clear the pixel counter, and hold writeEn low.
REQ-018 PAINT: SHALL hold writeEn high for exactly TILE_SIZE*TILE_SIZE cycles and scan in raster order, x fastest; x = origin_x + cnt low half, y = origin_y + cnt high half.
REQ-019 The pixel counter SHALL be 2*log2(TILE_SIZE) bits; on the last pixel (all ones) the FSM SHALL go to DONE, and the counter SHALL NOT wrap into a second pass.
REQ-020 DONE, one cycle: SHALL pulse done for the winner, clear gnt, hold writeEn low, then return to IDLE.
REQ-021 Latency from req sampled in IDLE SHALL be: gnt the next cycle, first writeEn 2 cycles after the sample, done at cycle TILE_SIZE^2+2.
REQ-022 Tile and colour SHALL be latched at grant; changes to req, tile_in or colour_in during LOAD, PAINT or DONE SHALL be ignored.
REQ-023 Requesters SHALL drop req on the edge ending DONE; a req still high when IDLE is re-entered SHALL be treated as a new request.
REQ-024 SHALL NOT assert writeEn outside PAINT; x, y and colour SHALL hold their last values outside PAINT.

Reset
REQ-025 On resetn low, SHALL immediately enter IDLE and clear gnt, done, writeEn, busy, x, y, colour, counter and the priority pointer; an in-progress paint SHALL be abandoned with no done pulse.
REQ-026 On resetn deassertion, SHALL sample req on the first rising clock edge.

Configuration
REQ-027 With macro TILE_ARB_ROUND_ROBIN_EN defined, SHALL arbitrate round-robin: the last winner gets lowest priority and the pointer updates at each grant; after reset the pointer SHALL favour requester 0.
REQ-028 Without TILE_ARB_ROUND_ROBIN_EN, SHALL use fixed priority per REQ-016 and SHALL NOT contain the pointer register.

Structure
REQ-029 Package graphics_pkg SHALL hold the state encoding, requester index constants (REQ_BOOT, REQ_PLAY, REQ_ECHO), colour width, and the X_BASE/Y_BASE/GAP defaults.
REQ-030 SHALL instantiate one sub-module pixel_scan_counter, which has clear/enable/last and produces the counter and x/y offsets; arbitration and FSM SHALL remain in tile_draw_arbiter.

Verification (TILE_SIZE=4 unless noted)
REQ-031 Single request: req=3'b010, tile 2'b11, colour 3'b100 -> gnt=010 next cycle, writeEn exactly 16 cycles, first (x,y)=(48,28), last (51,31), done[1] at cycle 18.
REQ-032 Simultaneous: req=3'b111 held -> fixed priority grants 0, 1, 2 in order; with TILE_ARB_ROUND_ROBIN_EN and all req kept high, grants rotate 0, 1, 2, 0.
REQ-033 Mid-paint change: tile_in and colour_in altered and req[0] dropped during PAINT -> all 16 pixels use latched values and done still pulses.
REQ-034 Reset at PAINT pixel 7 -> writeEn, gnt and busy go low asynchronously, no done pulse; the next request paints a full 16 pixels.
REQ-035 Default TILE_SIZE=16, tile 0 -> exactly 256 writeEn cycles spanning (40,20)..(55,35), with no counter wrap.
REQ-036 Back-to-back: requester 2 holds req through DONE -> it is re-granted the cycle after IDLE is re-entered.

Source files
------------

// File: rtl/graphics_pkg.sv
// Shared types and constants for the tile drawing path:
// FSM encoding, requester indices, colour width and placement defaults.
package graphics_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_PAINT = 2'd2,
      ST_DONE  = 2'd3
   } draw_state_t;

   localparam int unsigned N_REQ    = 3;
   localparam int unsigned REQ_BOOT = 0;
   localparam int unsigned REQ_PLAY = 1;
   localparam int unsigned REQ_ECHO = 2;

   localparam int unsigned COLOUR_W = 3;
   localparam int unsigned TILE_W   = 2;

   localparam int unsigned X_BASE_DEF = 40;
   localparam int unsigned Y_BASE_DEF = 20;
   localparam int unsigned GAP_DEF    = 4;

   function automatic logic [N_REQ-1:0] req_onehot(input logic [1:0] idx);
      return N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/pixel_scan_counter.sv
// Raster pixel counter for one tile; x offset is the low half.
// Offsets reflect the count being loaded on the coming edge.
module pixel_scan_counter #(
   parameter int unsigned HW = 2
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          clear,
   input  logic          enable,
   output logic [HW-1:0] x_off,
   output logic [HW-1:0] y_off,
   output logic          last
);

   localparam logic [2*HW-1:0] ONE = 1;

   logic [2*HW-1:0] count;
   logic [2*HW-1:0] count_nxt;

   always_comb begin
      count_nxt = count;
      if (clear)
         count_nxt = '0;
      else if (enable)
         count_nxt = count + ONE;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         count <= '0;
      else
         count <= count_nxt;
   end

   assign {y_off, x_off} = count_nxt;
   assign last = &count;

endmodule

// File: rtl/tile_draw_arbiter.sv
// Arbitrates three paint requesters and rasterises one tile to the VGA port.
// Define TILE_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module tile_draw_arbiter
   import graphics_pkg::*;
#(
   parameter int unsigned TILE_SIZE = 16,
   parameter int unsigned GAP       = GAP_DEF,
   parameter int unsigned X_BASE    = X_BASE_DEF,
   parameter int unsigned Y_BASE    = Y_BASE_DEF
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*TILE_W-1:0]   tile_in,
   input  logic [N_REQ*COLOUR_W-1:0] colour_in,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          done,
   output logic [7:0]                x,
   output logic [6:0]                y,
   output logic [COLOUR_W-1:0]       colour,
   output logic                      writeEn,
   output logic                      busy
);

   localparam int unsigned HW    = $clog2(TILE_SIZE);
   localparam int unsigned PITCH = TILE_SIZE + GAP;

   draw_state_t         state;
   logic [TILE_W-1:0]   tile_q;
   logic [COLOUR_W-1:0] colour_q;
   logic [TILE_W-1:0]   tile_sel;
   logic [COLOUR_W-1:0] col_sel;
   logic [1:0]          win;
   logic                win_vld;
   logic [HW-1:0]       x_off;
   logic [HW-1:0]       y_off;
   logic                last;
   logic                scan_clr;
   logic                scan_en;
   logic [7:0]          org_x;
   logic [6:0]          org_y;

`ifdef TILE_ARB_ROUND_ROBIN_EN
   logic [1:0] ptr;
   logic [1:0] idx;

   // ptr holds the highest-priority requester; lowest offset wins
   always_comb begin
      win     = 2'(REQ_BOOT);
      win_vld = |req;
      idx     = 2'd0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = 2'((int'(ptr) + k) % N_REQ);
         if (req[idx])
            win = idx;
      end
   end
`else
   always_comb begin
      win_vld = |req;
      if (req[REQ_BOOT])
         win = 2'(REQ_BOOT);
      else if (req[REQ_PLAY])
         win = 2'(REQ_PLAY);
      else
         win = 2'(REQ_ECHO);
   end
`endif

   always_comb begin
      tile_sel = tile_in[TILE_W*REQ_BOOT +: TILE_W];
      col_sel  = colour_in[COLOUR_W*REQ_BOOT +: COLOUR_W];
      if (win == 2'(REQ_PLAY)) begin
         tile_sel = tile_in[TILE_W*REQ_PLAY +: TILE_W];
         col_sel  = colour_in[COLOUR_W*REQ_PLAY +: COLOUR_W];
      end else if (win == 2'(REQ_ECHO)) begin
         tile_sel = tile_in[TILE_W*REQ_ECHO +: TILE_W];
         col_sel  = colour_in[COLOUR_W*REQ_ECHO +: COLOUR_W];
      end
   end

   assign org_x = 8'(X_BASE) + 8'(PITCH) * {7'd0, tile_q[0]};
   assign org_y = 7'(Y_BASE) + 7'(PITCH) * {6'd0, tile_q[1]};

   assign scan_clr = (state == ST_LOAD);
   assign scan_en  = (state == ST_PAINT) && !last;

   pixel_scan_counter #(
      .HW(HW)
   ) u_scan (
      .clock  (clock),
      .resetn (resetn),
      .clear  (scan_clr),
      .enable (scan_en),
      .x_off  (x_off),
      .y_off  (y_off),
      .last   (last)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         done     <= '0;
         writeEn  <= 1'b0;
         busy     <= 1'b0;
         x        <= '0;
         y        <= '0;
         colour   <= '0;
         tile_q   <= '0;
         colour_q <= '0;
`ifdef TILE_ARB_ROUND_ROBIN_EN
         ptr      <= 2'(REQ_BOOT);
`endif
      end else begin
         done <= '0;
         unique case (state)
            ST_IDLE: begin
               if (win_vld) begin
                  state    <= ST_LOAD;
                  busy     <= 1'b1;
                  gnt      <= req_onehot(win);
                  tile_q   <= tile_sel;
                  colour_q <= col_sel;
`ifdef TILE_ARB_ROUND_ROBIN_EN
                  ptr      <= (win == 2'(N_REQ - 1)) ? 2'd0 : win + 2'd1;
`endif
               end
            end
            ST_LOAD: begin
               state   <= ST_PAINT;
               writeEn <= 1'b1;
               x       <= org_x + 8'(x_off);
               y       <= org_y + 7'(y_off);
               colour  <= colour_q;
            end
            ST_PAINT: begin
               if (last) begin
                  state   <= ST_DONE;
                  writeEn <= 1'b0;
                  gnt     <= '0;
                  done    <= gnt;
               end else begin
                  x <= org_x + 8'(x_off);
                  y <= org_y + 7'(y_off);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
